// File: rtl/easyaxi_pkg.sv
// easyaxi_pkg: shared AXI burst/response constants and the queued request control word
package easyaxi_pkg;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_SIZE_W = 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSV   = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // id and address widths are per-instance, so only the fixed-width fields live here
    typedef struct packed {
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_SIZE_W-1:0] size;
        logic [1:0]            burst;
        logic                  decerr;
    } req_ctrl_t;

    // WRAP lengths that form a power-of-two window; anything else degrades to INCR
    function automatic logic wrap_len_ok(input logic [AXI_LEN_W-1:0] len);
        return len inside {8'd1, 8'd3, 8'd7, 8'd15};
    endfunction
endpackage

// File: rtl/easyaxi_slv_ost_if.sv
// easyaxi_slv_ost_if: AXI read-address and read-data channel bundle
interface easyaxi_slv_ost_if
    import easyaxi_pkg::*;
#(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic                  arvalid;
    logic                  arready;
    logic [ID_W-1:0]       arid;
    logic [ADDR_W-1:0]     araddr;
    logic [AXI_LEN_W-1:0]  arlen;
    logic [AXI_SIZE_W-1:0] arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [ID_W-1:0]       rid;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );
    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/easyaxi_sync_fifo.sv
// easyaxi_sync_fifo: single-clock FIFO with registered full/empty and same-cycle push/pop
module easyaxi_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt, cnt_nxt;
    logic             do_push, do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Occupancy after this cycle's push/pop, used to register the flags
    always_comb cnt_nxt = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // Pointers, occupancy and registered flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            cnt   <= cnt_nxt;
            full  <= cnt_nxt == (AW+1)'(DEPTH);
            empty <= cnt_nxt == '0;
        end
    end
endmodule

// File: rtl/easyaxi_slv_ost.sv
// easyaxi_slv_ost: AXI read-only slave with queued outstanding requests served in order
module easyaxi_slv_ost
    import easyaxi_pkg::*;
#(
    parameter int          ID_W      = 4,
    parameter int          ADDR_W    = 16,
    parameter int          DATA_W    = 32,
    parameter int          OST_DEPTH = 4,
    parameter int          RD_LAT    = 3,
    parameter logic [63:0] BASE_ADDR = '0,
    parameter logic [63:0] RANGE     = 64'd1 << ADDR_W
) (
    input logic               clk,
    input logic               rst,
    easyaxi_slv_ost_if.slave  axi_slv
);
    localparam int FW = ID_W + ADDR_W + $bits(req_ctrl_t);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DATA} state_t;

    state_t            state, state_nxt;
    logic              full, empty, push, pop, ar_decerr, last;
    req_ctrl_t         ar_ctrl, h_ctrl, ctrl;
    logic [FW-1:0]     fifo_wdata, fifo_rdata;
    logic [ID_W-1:0]   h_id, cur_id;
    logic [ADDR_W-1:0] h_addr, start, addr, addr_nxt;
    logic [ADDR_W-1:0] nb, len_b, bound, wrap_nxt, incr_nxt;
    logic [7:0]        idx;
    logic [3:0]        cnt;

    assign ar_decerr = (64'(axi_slv.araddr) < BASE_ADDR) || (64'(axi_slv.araddr) >= BASE_ADDR + RANGE);
    assign ar_ctrl   = '{len: axi_slv.arlen, size: axi_slv.arsize, burst: axi_slv.arburst, decerr: ar_decerr};
    assign fifo_wdata = {axi_slv.arid, axi_slv.araddr, ar_ctrl};
    assign {h_id, h_addr, h_ctrl} = fifo_rdata;
    assign push = axi_slv.arvalid & ~full;
    assign axi_slv.arready = ~full;

    easyaxi_sync_fifo #(.WIDTH(FW), .DEPTH(OST_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (full),
        .empty (empty)
    );

    assign last = idx == ctrl.len;

    // Address of the following beat; INCR is recomputed from the aligned start so it never drifts
    always_comb begin
        nb       = ADDR_W'(1) << ctrl.size;
        len_b    = (ADDR_W'(ctrl.len) + ADDR_W'(1)) << ctrl.size;
        bound    = start & ~(len_b - ADDR_W'(1));
        wrap_nxt = (addr + nb == bound + len_b) ? bound : addr + nb;
        incr_nxt = (start & ~(nb - ADDR_W'(1))) + ((ADDR_W'(idx) + ADDR_W'(1)) << ctrl.size);
        addr_nxt = ctrl.burst == BURST_FIXED ? addr :
                   ctrl.burst == BURST_RSV ? '0 :
                   (ctrl.burst == BURST_WRAP && wrap_len_ok(ctrl.len)) ? wrap_nxt : incr_nxt;
    end

    // Engine state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_nxt;
    end

    // Engine next state and FIFO pop; decode errors skip the wait phase entirely
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = h_ctrl.decerr ? S_DATA : S_WAIT;
                end
            end
            S_WAIT: if (cnt == '0) state_nxt = S_DATA;
            S_DATA: if (axi_slv.rready) state_nxt = last ? S_IDLE : ctrl.decerr ? S_DATA : S_WAIT;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Current request, beat address/index and per-beat wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_id <= '0;
            start  <= '0;
            addr   <= '0;
            ctrl   <= '0;
            idx    <= '0;
            cnt    <= '0;
        end else if (pop) begin
            cur_id <= h_id;
            start  <= h_addr;
            addr   <= h_addr;
            ctrl   <= h_ctrl;
            idx    <= '0;
            cnt    <= 4'(RD_LAT);
        end else if (state == S_WAIT && cnt != '0) begin
            cnt <= cnt - 4'd1;
        end else if (state == S_DATA && axi_slv.rready && !last) begin
            addr <= addr_nxt;
            idx  <= idx + 8'd1;
            cnt  <= 4'(RD_LAT);
        end
    end

    assign axi_slv.rvalid = state == S_DATA;
    assign axi_slv.rlast  = axi_slv.rvalid & last;
    assign axi_slv.rid    = cur_id;
    assign axi_slv.rdata  = ctrl.decerr ? '0 : DATA_W'({cur_id, addr});
    assign axi_slv.rresp  = ctrl.decerr ? RESP_DECERR :
                            (ctrl.burst == BURST_RSV || (last && &cur_id)) ? RESP_SLVERR : RESP_OKAY;
endmodule

// File: tb/tb_easyaxi_slv_ost.sv
// tb_easyaxi_slv_ost: randomized and directed checks of the outstanding-request read slave
module tb_easyaxi_slv_ost;
    import easyaxi_pkg::*;

    localparam int RD_LAT = 3;
    localparam int DEPTH  = 4;
    localparam int BASE   = 32'h0008;
    localparam int RNG    = 32'h7FF8;
    localparam int LIMIT  = 3000;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    easyaxi_slv_ost_if #(.ID_W(4), .ADDR_W(16), .DATA_W(32)) axi_slv ();

    easyaxi_slv_ost #(
        .ID_W(4), .ADDR_W(16), .DATA_W(32), .OST_DEPTH(DEPTH), .RD_LAT(RD_LAT),
        .BASE_ADDR(64'(BASE)), .RANGE(64'(RNG))
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .axi_slv (axi_slv)
    );

    always #5 clk = ~clk;

    beat_t       exp_q[$];
    int          beat_cyc[$];
    beat_t       e;
    int          n_tests = 0, n_fail = 0;
    int          cyc = 0, n_beats = 0, ar_cyc = 0, beats_at_ar = 0;
    int          rr_mode = 0;
    int          nb0;
    logic        prev_stall = 1'b0;
    logic [39:0] prev_pl = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: expand one accepted request into its expected beats from the burst rules
    function automatic void model_push(input int id, input int a, input int len, input int size, input int burst);
        int nb, lb, bnd, cur;
        bit de, wrp;
        beat_t b;
        nb  = 1 << size;
        lb  = (len + 1) * nb;
        bnd = (a / lb) * lb;
        cur = a;
        de  = (a < BASE) || (a >= BASE + RNG);
        wrp = (burst == 2) && (len == 1 || len == 3 || len == 7 || len == 15);
        for (int i = 0; i <= len; i++) begin
            if (i > 0) begin
                if (burst == 3) cur = 0;
                else if (wrp) begin
                    cur = (cur + nb) % 65536;
                    if (cur == (bnd + lb) % 65536) cur = bnd;
                end else if (burst == 1 || burst == 2) cur = ((a / nb) * nb + i * nb) % 65536;
            end
            b.id   = id[3:0];
            b.data = de ? 32'd0 : 32'((id << 16) | cur);
            b.resp = de ? 2'd3 : (burst == 3 || (i == len && id == 15)) ? 2'd2 : 2'd0;
            b.last = i == len;
            exp_q.push_back(b);
        end
    endfunction

    // Monitor: sample away from the rising edge, score R beats and check stall stability
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("r_stable", {axi_slv.rvalid, axi_slv.rid, axi_slv.rdata, axi_slv.rresp, axi_slv.rlast}, prev_pl);
            if (axi_slv.arvalid && axi_slv.arready) begin
                model_push(int'(axi_slv.arid), int'(axi_slv.araddr), int'(axi_slv.arlen),
                           int'(axi_slv.arsize), int'(axi_slv.arburst));
                ar_cyc      = cyc;
                beats_at_ar = n_beats;
            end
            if (axi_slv.rvalid && axi_slv.rready) begin
                n_beats++;
                beat_cyc.push_back(cyc);
                chk("r_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rid", axi_slv.rid, e.id);
                    chk("rdata", axi_slv.rdata, e.data);
                    chk("rresp", axi_slv.rresp, e.resp);
                    chk("rlast", axi_slv.rlast, e.last);
                end
            end
            prev_stall = axi_slv.rvalid & ~axi_slv.rready;
            prev_pl    = {axi_slv.rvalid, axi_slv.rid, axi_slv.rdata, axi_slv.rresp, axi_slv.rlast};
        end
    end

    // R-channel ready: always high, always low, or random
    initial begin
        axi_slv.rready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            axi_slv.rready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the accepting edge
    task automatic send_ar(input logic [3:0] id, input logic [15:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        axi_slv.arvalid = 1'b1;
        axi_slv.arid    = id;
        axi_slv.araddr  = a;
        axi_slv.arlen   = len;
        axi_slv.arsize  = size;
        axi_slv.arburst = burst;
        @(negedge clk);
        while (!axi_slv.arready && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        chk("ar_accept", t < LIMIT, 1);
        @(posedge clk);
        #1;
        axi_slv.arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || axi_slv.rvalid) && t < LIMIT) begin
            @(negedge clk);
            t++;
        end
        chk("drain", t < LIMIT, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_timing(input string tag, input int n, input int first, input int gap);
        chk({tag, "_beats"}, beat_cyc.size(), n);
        if (beat_cyc.size() >= 2) begin
            chk({tag, "_first"}, beat_cyc[0] - ar_cyc, first);
            chk({tag, "_gap"}, beat_cyc[1] - beat_cyc[0], gap);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi_slv.arvalid = 1'b0;
        axi_slv.arid    = '0;
        axi_slv.araddr  = '0;
        axi_slv.arlen   = '0;
        axi_slv.arsize  = '0;
        axi_slv.arburst = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_arready", axi_slv.arready, 1);
        chk("rst_rvalid", axi_slv.rvalid, 0);
        chk("rst_rlast", axi_slv.rlast, 0);
        chk("rst_rid", axi_slv.rid, 0);
        chk("rst_rdata", axi_slv.rdata, 0);
        chk("rst_rresp", axi_slv.rresp, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        beat_cyc.delete();
        send_ar(4'd2, 16'h0010, 8'd3, 3'd2, BURST_INCR);
        wait_drain();
        check_timing("incr", 4, RD_LAT + 3, RD_LAT + 2);

        send_ar(4'd1, 16'h0038, 8'd3, 3'd3, BURST_WRAP);
        wait_drain();

        send_ar(4'hF, 16'h0100, 8'd1, 3'd2, BURST_INCR);
        wait_drain();

        beat_cyc.delete();
        send_ar(4'd5, 16'h9000, 8'd2, 3'd2, BURST_INCR);
        wait_drain();
        check_timing("decerr", 3, 2, 1);

        send_ar(4'd6, 16'h0007, 8'd0, 3'd2, BURST_INCR);
        send_ar(4'd6, 16'h0008, 8'd0, 3'd2, BURST_INCR);
        send_ar(4'd7, 16'h7FFC, 8'd1, 3'd2, BURST_INCR);
        send_ar(4'd7, 16'h8000, 8'd0, 3'd2, BURST_INCR);
        send_ar(4'd8, 16'h0040, 8'd2, 3'd1, BURST_RSV);
        send_ar(4'd9, 16'h0050, 8'd2, 3'd2, BURST_WRAP);
        send_ar(4'hA, 16'h0060, 8'd2, 3'd0, BURST_FIXED);
        send_ar(4'hB, 16'hFFFC, 8'd1, 3'd2, BURST_INCR);
        wait_drain();

        rr_mode = 1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < DEPTH + 1; i++) send_ar(4'(i + 1), 16'(16'h0100 + 16 * i), 8'd1, 3'd2, BURST_INCR);
        chk("full_arready", axi_slv.arready, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("full_hold", axi_slv.arready, 0);
        nb0     = n_beats;
        rr_mode = 0;
        send_ar(4'd6, 16'h0200, 8'd1, 3'd2, BURST_INCR);
        chk("ar_after_burst", (beats_at_ar - nb0) >= 2, 1);
        wait_drain();

        rr_mode = 2;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] len;
            logic [1:0] bt;
            bt  = 2'($urandom_range(0, 3));
            len = $urandom_range(0, 1) ? 8'($urandom_range(0, 9)) : 8'((2 << $urandom_range(0, 3)) - 1);
            send_ar(4'($urandom_range(0, 15)), 16'($urandom_range(0, 16'h9000)), len,
                    3'($urandom_range(0, 3)), bt);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 12)) @(posedge clk);
                #1;
            end
        end
        wait_drain();

        rr_mode = 0;
        nb0     = n_beats;
        send_ar(4'd3, 16'h0200, 8'd7, 3'd2, BURST_INCR);
        send_ar(4'd4, 16'h0300, 8'd2, 3'd2, BURST_INCR);
        send_ar(4'd5, 16'h0400, 8'd2, 3'd2, BURST_INCR);
        begin
            int t = 0;
            while (n_beats < nb0 + 1 && t < LIMIT) begin
                @(negedge clk);
                t++;
            end
            chk("rst_beat1", t < LIMIT, 1);
            rr_mode = 1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!axi_slv.rvalid && t < LIMIT);
            chk("rst_beat2", t < LIMIT, 1);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rvalid", axi_slv.rvalid, 0);
        chk("midrst_arready", axi_slv.arready, 1);
        chk("midrst_rlast", axi_slv.rlast, 0);
        chk("midrst_rdata", axi_slv.rdata, 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rr_mode = 0;
        nb0     = n_beats;
        send_ar(4'd7, 16'h0300, 8'd1, 3'd2, BURST_INCR);
        wait_drain();
        chk("post_rst_beats", n_beats - nb0, 2);
        chk("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
